// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based hazard detection, operand forwarding and
// branch flush control for the 5-stage pipeline, with saturating event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_regwr,
    input  logic              id_memtoreg,
    input  logic              ex_br_taken,
    output logic              stall,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0]       FWD_RF    = 2'd0;
    localparam logic [1:0]       FWD_EXMEM = 2'd1;
    localparam logic [1:0]       FWD_MEMWB = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // EX keeps the source operands so its forwarding selects can be computed.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rw;
        logic              regwr;
        logic              load;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
    } ex_entry_t;

    // MEM and WB only ever act as producers.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rw;
        logic              regwr;
    } wr_entry_t;

    ex_entry_t ex_q;
    wr_entry_t mem_q;
    wr_entry_t wb_q;
    logic      hazard_c;

    // Producer entry writes register r; r0 is hardwired and never matches.
    function automatic logic wr_match(
        input logic              valid,
        input logic              regwr,
        input logic [REG_AW-1:0] rw,
        input logic [REG_AW-1:0] r
    );
        return valid & regwr & (rw == r) & (r != '0);
    endfunction

    // Data hazard between the ID sources and in-flight producers.
    always_comb begin
        hazard_c = 1'b0;
        if (FWD_EN != 0) begin
            hazard_c = ex_q.load &
                ((id_use_rs & wr_match(ex_q.valid, ex_q.regwr, ex_q.rw, id_rs)) |
                 (id_use_rt & wr_match(ex_q.valid, ex_q.regwr, ex_q.rw, id_rt)));
        end else begin
            hazard_c =
                (id_use_rs & (wr_match(ex_q.valid, ex_q.regwr, ex_q.rw, id_rs) |
                              wr_match(mem_q.valid, mem_q.regwr, mem_q.rw, id_rs))) |
                (id_use_rt & (wr_match(ex_q.valid, ex_q.regwr, ex_q.rw, id_rt) |
                              wr_match(mem_q.valid, mem_q.regwr, mem_q.rw, id_rt)));
        end
    end

    // Stall / bubble / flush; a taken branch squashes ID so it overrides stall.
    always_comb begin
        stall       = id_valid & hazard_c & ~ex_br_taken;
        bubble_idex = stall | ex_br_taken;
        flush_ifid  = ex_br_taken;
    end

    // Operand forwarding for the EX instruction, youngest producer first.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if ((FWD_EN != 0) && ex_q.valid) begin
            if (ex_q.use_rs) begin
                if (wr_match(mem_q.valid, mem_q.regwr, mem_q.rw, ex_q.rs)) begin
                    fwd_a = FWD_EXMEM;
                end else if (wr_match(wb_q.valid, wb_q.regwr, wb_q.rw, ex_q.rs)) begin
                    fwd_a = FWD_MEMWB;
                end
            end
            if (ex_q.use_rt) begin
                if (wr_match(mem_q.valid, mem_q.regwr, mem_q.rw, ex_q.rt)) begin
                    fwd_b = FWD_EXMEM;
                end else if (wr_match(wb_q.valid, wb_q.regwr, wb_q.rw, ex_q.rt)) begin
                    fwd_b = FWD_MEMWB;
                end
            end
        end
    end

    // Scoreboard advances with the pipeline registers on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{valid: ex_q.valid, rw: ex_q.rw, regwr: ex_q.regwr};
            ex_q  <= '{valid:  id_valid & ~bubble_idex,
                       rw:     id_rw,
                       regwr:  id_regwr,
                       load:   id_memtoreg,
                       rs:     id_rs,
                       rt:     id_rt,
                       use_rs: id_use_rs,
                       use_rt: id_use_rt};
        end
    end

    // Saturating performance counters.
    always_ff @(negedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ex_br_taken && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (forwarding, stall-only, stall-only
// with 2-bit counters) share one stimulus stream and are checked against a
// producer-age history model, a directed vector table and hand sequences.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        bit       rst;
        bit       v;
        bit [4:0] rw;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
        bit       wr;
        bit       ld;
        bit       br;
    } vin_t;

    typedef struct packed {
        bit       v;
        bit [4:0] rw;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
        bit       wr;
        bit       ld;
    } rec_t;

    typedef struct packed {
        bit       s;
        bit       b;
        bit       f;
        bit [1:0] fa;
        bit [1:0] fb;
    } out_t;

    typedef struct {
        vin_t i;
        out_t e1;
        bit   s0;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_rw;
    logic       id_regwr;
    logic       id_memtoreg;
    logic       ex_br_taken;

    logic        s1, b1, f1, s0, b0, f0, s2, b2, f2;
    logic [1:0]  fa1, fb1, fa0, fb0, fa2, fb2;
    logic [15:0] sc1, fc1, sc0, fc0;
    logic [1:0]  sc2, fc2;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction history by age: index 0 = one cycle old (EX), 1 = MEM, 2 = WB.
    rec_t h1 [3];
    rec_t h0 [3];
    int cs1 = 0, cf1 = 0, cs0 = 0, cf0 = 0, cs2 = 0, cf2 = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
        .id_memtoreg(id_memtoreg), .ex_br_taken(ex_br_taken), .stall(s1), .bubble_idex(b1),
        .flush_ifid(f1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
        .id_memtoreg(id_memtoreg), .ex_br_taken(ex_br_taken), .stall(s0), .bubble_idex(b0),
        .flush_ifid(f0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
        .id_memtoreg(id_memtoreg), .ex_br_taken(ex_br_taken), .stall(s2), .bubble_idex(b2),
        .flush_ifid(f2), .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(sc2), .flush_cnt(fc2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit writes(input rec_t e, input bit [4:0] r);
        return e.v && e.wr && (e.rw == r) && (r != 5'd0);
    endfunction

    function automatic bit [1:0] fsel(input bit u, input bit [4:0] r, input rec_t a2, input rec_t a3);
        if (!u) return 2'd0;
        if (writes(a2, r)) return 2'd1;
        if (writes(a3, r)) return 2'd2;
        return 2'd0;
    endfunction

    // Expected outputs from the ID instruction and the producers 1..3 cycles older.
    function automatic out_t ref_out(input vin_t i, input rec_t a1, input rec_t a2,
                                     input rec_t a3, input bit fe);
        out_t o;
        bit   haz;
        o = '0;
        if (fe) begin
            haz = a1.ld && ((i.urs && writes(a1, i.rs)) || (i.urt && writes(a1, i.rt)));
        end else begin
            haz = (i.urs && (writes(a1, i.rs) || writes(a2, i.rs))) ||
                  (i.urt && (writes(a1, i.rt) || writes(a2, i.rt)));
        end
        o.f = i.br;
        o.s = i.v && haz && !i.br;
        o.b = o.s || i.br;
        if (fe && a1.v) begin
            o.fa = fsel(a1.urs, a1.rs, a2, a3);
            o.fb = fsel(a1.urt, a1.rt, a2, a3);
        end
        return o;
    endfunction

    function automatic rec_t to_rec(input vin_t i, input bit bub);
        rec_t r;
        r.v = i.v && !bub;
        r.rw = i.rw;
        r.rs = i.rs;
        r.rt = i.rt;
        r.urs = i.urs;
        r.urt = i.urt;
        r.wr = i.wr;
        r.ld = i.ld;
        return r;
    endfunction

    function automatic vin_t mk(input int rst_i, input int v, input int rw, input int rs,
                                input int rt, input int urs, input int urt, input int wr,
                                input int ld, input int br);
        vin_t m;
        m.rst = (rst_i != 0);
        m.v   = (v != 0);
        m.rw  = 5'(rw);
        m.rs  = 5'(rs);
        m.rt  = 5'(rt);
        m.urs = (urs != 0);
        m.urt = (urt != 0);
        m.wr  = (wr != 0);
        m.ld  = (ld != 0);
        m.br  = (br != 0);
        return m;
    endfunction

    function automatic out_t eo(input int s, input int b, input int f, input int fa, input int fb);
        out_t o;
        o.s  = (s != 0);
        o.b  = (b != 0);
        o.f  = (f != 0);
        o.fa = 2'(fa);
        o.fb = 2'(fb);
        return o;
    endfunction

    // One pipeline cycle: drive after the rising edge, check, then follow the falling edge.
    task automatic step(input vin_t i, input bit use_tab, input out_t e1, input bit e_s0);
        out_t o1;
        out_t o0;
        @(posedge clk);
        rst = i.rst;
        id_valid = i.v;
        id_rw = i.rw;
        id_rs = i.rs;
        id_rt = i.rt;
        id_use_rs = i.urs;
        id_use_rt = i.urt;
        id_regwr = i.wr;
        id_memtoreg = i.ld;
        ex_br_taken = i.br;
        #1;
        o1 = ref_out(i, h1[0], h1[1], h1[2], 1'b1);
        o0 = ref_out(i, h0[0], h0[1], h0[2], 1'b0);
        chk("u1_stall", 32'(s1), 32'(o1.s));
        chk("u1_bubble", 32'(b1), 32'(o1.b));
        chk("u1_flush", 32'(f1), 32'(o1.f));
        chk("u1_fwd_a", 32'(fa1), 32'(o1.fa));
        chk("u1_fwd_b", 32'(fb1), 32'(o1.fb));
        chk("u0_stall", 32'(s0), 32'(o0.s));
        chk("u0_bubble", 32'(b0), 32'(o0.b));
        chk("u0_flush", 32'(f0), 32'(o0.f));
        chk("u0_fwd_a", 32'(fa0), 32'(o0.fa));
        chk("u0_fwd_b", 32'(fb0), 32'(o0.fb));
        chk("u2_stall", 32'(s2), 32'(o0.s));
        if (use_tab) begin
            chk("tab_u1_stall", 32'(s1), 32'(e1.s));
            chk("tab_u1_bubble", 32'(b1), 32'(e1.b));
            chk("tab_u1_flush", 32'(f1), 32'(e1.f));
            chk("tab_u1_fwd_a", 32'(fa1), 32'(e1.fa));
            chk("tab_u1_fwd_b", 32'(fb1), 32'(e1.fb));
            chk("tab_u0_stall", 32'(s0), 32'(e_s0));
        end
        @(negedge clk);
        #1;
        if (i.rst) begin
            for (int k = 0; k < 3; k++) begin
                h1[k] = '0;
                h0[k] = '0;
            end
            cs1 = 0; cf1 = 0; cs0 = 0; cf0 = 0; cs2 = 0; cf2 = 0;
        end else begin
            h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = to_rec(i, o1.b);
            h0[2] = h0[1]; h0[1] = h0[0]; h0[0] = to_rec(i, o0.b);
            if (o1.s && cs1 < 65535) cs1++;
            if (i.br && cf1 < 65535) cf1++;
            if (o0.s && cs0 < 65535) cs0++;
            if (i.br && cf0 < 65535) cf0++;
            if (o0.s && cs2 < 3) cs2++;
            if (i.br && cf2 < 3) cf2++;
        end
        chk("u1_stall_cnt", 32'(sc1), 32'(cs1));
        chk("u1_flush_cnt", 32'(fc1), 32'(cf1));
        chk("u0_stall_cnt", 32'(sc0), 32'(cs0));
        chk("u0_flush_cnt", 32'(fc0), 32'(cf0));
        chk("u2_stall_cnt", 32'(sc2), 32'(cs2));
        chk("u2_flush_cnt", 32'(fc2), 32'(cf2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        vin_t r;
        vin_t nop;

        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_rw = '0; id_regwr = 1'b0; id_memtoreg = 1'b0; ex_br_taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            h1[k] = '0;
            h0[k] = '0;
        end
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        //            rst v  rw rs rt urs urt wr ld br       u1: s b f fa fb    u0 stall
        tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, 0, 0), 1'b0};
        tbl[1]  = '{mk(0, 1, 3, 1, 2, 1, 1, 1, 0, 0), eo(0, 0, 0, 0, 0), 1'b0}; // add r3,r1,r2
        tbl[2]  = '{mk(0, 1, 4, 3, 3, 1, 1, 1, 0, 0), eo(0, 0, 0, 0, 0), 1'b1}; // add r4,r3,r3
        tbl[3]  = '{mk(0, 1, 4, 3, 3, 1, 1, 1, 0, 0), eo(0, 0, 0, 1, 1), 1'b1};
        tbl[4]  = '{mk(0, 1, 4, 3, 3, 1, 1, 1, 0, 0), eo(0, 0, 0, 2, 2), 1'b0};
        tbl[5]  = '{mk(0, 1, 5, 1, 0, 1, 0, 1, 1, 0), eo(0, 0, 0, 0, 0), 1'b0}; // lw r5
        tbl[6]  = '{mk(0, 1, 6, 5, 2, 1, 1, 1, 0, 0), eo(1, 1, 0, 0, 0), 1'b1}; // sub r6,r5,r2
        tbl[7]  = '{mk(0, 1, 6, 5, 2, 1, 1, 1, 0, 0), eo(0, 0, 0, 0, 0), 1'b1};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, 2, 0), 1'b0};
        tbl[9]  = '{mk(0, 1, 0, 1, 2, 1, 1, 1, 0, 0), eo(0, 0, 0, 0, 0), 1'b0}; // add r0
        tbl[10] = '{mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 0), eo(0, 0, 0, 0, 0), 1'b0}; // lw r0,(r0)
        tbl[11] = '{mk(0, 1, 7, 0, 0, 1, 1, 1, 0, 0), eo(0, 0, 0, 0, 0), 1'b0}; // add r7,r0,r0
        tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, 0, 0), 1'b0};
        tbl[13] = '{mk(0, 1, 8, 1, 0, 1, 0, 1, 1, 0), eo(0, 0, 0, 0, 0), 1'b0}; // lw r8
        tbl[14] = '{mk(0, 1, 9, 8, 8, 1, 1, 1, 0, 1), eo(0, 1, 1, 0, 0), 1'b0}; // use + branch
        tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, 0, 0), 1'b0};

        for (int k = 0; k < 16; k++) begin
            step(tbl[k].i, 1'b1, tbl[k].e1, tbl[k].s0);
        end
        chk("dir_u1_stall_cnt", 32'(sc1), 32'd1);
        chk("dir_u1_flush_cnt", 32'(fc1), 32'd1);
        chk("dir_u0_stall_cnt", 32'(sc0), 32'd4);
        chk("dir_u2_stall_cnt_sat", 32'(sc2), 32'd3);

        // Further stall-only stalls: the 2-bit counter must hold at 3.
        step(mk(0, 1, 10, 1, 2, 1, 1, 1, 0, 0), 1'b0, '0, 1'b0);
        step(mk(0, 1, 11, 10, 10, 1, 1, 1, 0, 0), 1'b1, eo(0, 0, 0, 0, 0), 1'b1);
        step(mk(0, 1, 11, 10, 10, 1, 1, 1, 0, 0), 1'b1, eo(0, 0, 0, 1, 1), 1'b1);
        step(nop, 1'b0, '0, 1'b0);
        chk("sat_u2_stall_cnt", 32'(sc2), 32'd3);
        chk("sat_u0_stall_cnt", 32'(sc0), 32'd6);

        // Reset in the middle of a stall with the dependent instruction held.
        step(mk(0, 1, 12, 1, 2, 1, 1, 1, 0, 0), 1'b0, '0, 1'b0);
        step(mk(0, 1, 13, 12, 12, 1, 1, 1, 0, 0), 1'b1, eo(0, 0, 0, 0, 0), 1'b1);
        step(mk(1, 1, 13, 12, 12, 1, 1, 1, 0, 0), 1'b0, '0, 1'b0);
        step(mk(0, 1, 13, 12, 12, 1, 1, 1, 0, 0), 1'b1, eo(0, 0, 0, 0, 0), 1'b0);
        chk("rst_u0_stall_cnt", 32'(sc0), 32'd0);
        chk("rst_u1_flush_cnt", 32'(fc1), 32'd0);
        chk("rst_u2_stall_cnt", 32'(sc2), 32'd0);
        step(nop, 1'b0, '0, 1'b0);

        // Reset and a taken branch together: counters stay cleared.
        step(mk(0, 1, 14, 1, 0, 1, 0, 1, 1, 0), 1'b0, '0, 1'b0);
        step(mk(1, 1, 15, 14, 14, 1, 1, 1, 0, 1), 1'b0, '0, 1'b0);
        chk("rstbr_u1_flush_cnt", 32'(fc1), 32'd0);
        chk("rstbr_u0_flush_cnt", 32'(fc0), 32'd0);
        chk("rstbr_u1_stall_cnt", 32'(sc1), 32'd0);
        step(nop, 1'b0, '0, 1'b0);

        // Random traffic over a small register set to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            r.rst = ($urandom_range(0, 49) == 0);
            r.v   = ($urandom_range(0, 3) != 0);
            r.rw  = 5'($urandom_range(0, 3));
            r.rs  = 5'($urandom_range(0, 3));
            r.rt  = 5'($urandom_range(0, 3));
            r.urs = ($urandom_range(0, 1) == 1);
            r.urt = ($urandom_range(0, 1) == 1);
            r.wr  = ($urandom_range(0, 3) != 0);
            r.ld  = r.wr && ($urandom_range(0, 2) == 0);
            r.br  = ($urandom_range(0, 7) == 0);
            step(r, 1'b0, '0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard-detection, forwarding and flush controller for the 5-stage pipelined CPU. It keeps a registered scoreboard of the destination registers of instructions in EX, MEM and WB. From that scoreboard it generates stall/bubble, flush and ALU-operand forwarding selects. A mode parameter selects full forwarding or stall-only operation, and saturating counters record stalls and flushes for performance measurement.

## Interface
Parameters:
- REG_AW, 5, register-index width
- FWD_EN, 1, 1 = forward EX/MEM and MEM/WB results, stall only on load-use; 0 = no forwarding, stall until the producer leaves MEM
- CNT_W, 16, width of stall/flush counters

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk, same edge as pipeline registers
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt
- id_rw  in  REG_AW  ID destination (after RegDst selection)
- id_regwr  in  1  ID instruction writes register file
- id_memtoreg  in  1  ID instruction is a load
- ex_br_taken  in  1  branch in EX resolved taken
- stall  out  1  hold PC and IF/ID register
- bubble_idex  out  1  load a bubble (all control zero) into ID/EX
- flush_ifid  out  1  squash the IF/ID instruction
- fwd_a, fwd_b  out  2  EX operand select: 0 register file, 1 EX/MEM ALU result, 2 MEM/WB write data
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Scoreboard entries: EX, MEM, WB. Each holds {valid, rw, regwr, load, rs, rt, use_rs, use_rt}. rs/rt/use fields are needed only in EX.
- Writing match(entry, r) = entry.valid & entry.regwr & entry.rw == r & r != 0.
- Register 0 never causes a hazard or a forward.
- The register file is write-through: a WB write is visible to the ID read in the same cycle. The WB entry therefore never stalls ID.
- Stall condition, with src = rs if use_rs, rt if use_rt:
  - FWD_EN=1: id_valid & EX.load & match(EX, src).
  - FWD_EN=0: id_valid & (match(EX, src) | match(MEM, src)).
- Flush: ex_br_taken drives flush_ifid=1 and bubble_idex=1. Flush overrides stall: stall=0 whenever ex_br_taken=1.
- bubble_idex = stall | ex_br_taken.
- Forwarding, FWD_EN=1, per operand of the EX entry (rs → fwd_a, rt → fwd_b):
  - MEM match has priority → 1.
  - Otherwise WB match → 2.
  - Otherwise 0.
  - A load in MEM is never forwarded; the load-use stall guarantees this.
- FWD_EN=0: fwd_a = fwd_b = 0 always.
- Scoreboard advance at each clock edge:
  - WB ← MEM, MEM ← EX.
  - EX ← ID fields with valid = id_valid & ~bubble_idex.
- stall_cnt increments on each cycle with stall=1. flush_cnt increments on each cycle with ex_br_taken=1. Both hold at 2^CNT_W−1.

## Timing
- stall, bubble_idex, flush_ifid, fwd_a and fwd_b are combinational from the inputs and registered scoreboard, valid in the same cycle.
- Load-use stalls last exactly 1 cycle (FWD_EN=1).
- With FWD_EN=0, a dependent instruction stalls 2 cycles behind its producer in EX and 1 cycle behind one in MEM.
- Back-to-back branches flush on every cycle that ex_br_taken is high.
- Reset: all scoreboard entries invalid. stall, bubble_idex, flush_ifid = 0, fwd_a = fwd_b = 0, and both counters = 0 from the first edge with rst=1.
- Reset mid-stall clears the stall the following cycle, regardless of inputs held.
- rst and ex_br_taken asserted together: reset wins and counters stay 0.

## Test plan
- FWD_EN=1: add r3 then add r4,r3,r3 back-to-back → no stall; next cycle fwd_a=fwd_b=1. Instruction two later reading r3 → fwd=2.
- FWD_EN=1: lw r5 then sub r6,r5,r2 → stall=1, bubble_idex=1 for one cycle. Then fwd_a=2 for the sub in EX; stall_cnt=1.
- FWD_EN=0: same add/add pair → stall for 2 cycles, fwd always 0; stall_cnt=2.
- Writes to r0 followed by reads of r0 → never stall, fwd=0.
- Load-use hazard in ID with ex_br_taken=1 in the same cycle → stall=0, flush_ifid=1, bubble_idex=1; flush_cnt=1.
- CNT_W=2, hold stall condition 5 cycles → stall_cnt reaches 3 and holds. Then rst=1 → all outputs and counters 0 at the next edge.
